// File: rtl/tlb_op_ctrl_if.sv
// Shared PhytranItem type and the controller's bus bundle: EX/CSR request side,
// CSR result side and the TLB search/read/write/flush ports.
`timescale 1ns/1ps

package tlb_op_pkg;
    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } phytran_item_t;
endpackage

interface tlb_op_ctrl_if #(
    parameter int TLBNUMSIZE = 4
);
    import tlb_op_pkg::*;

    // request handshake and INVTLB operands
    logic                  op_valid;
    logic                  op_ready;
    logic [2:0]            op_code;
    logic [2:0]            inv_op;
    logic [9:0]            inv_asid;
    logic [18:0]           inv_va;

    // CSR snapshot inputs
    logic [TLBNUMSIZE-1:0] csr_idx_index;
    logic [5:0]            csr_idx_ps;
    logic                  csr_idx_ne;
    logic [18:0]           csr_ehi_vppn;
    logic [9:0]            csr_asid;
    phytran_item_t         csr_elo0;
    phytran_item_t         csr_elo1;
    logic                  csr_elo_g;
    logic                  csr_ecode_refill;

    // TLB search port
    logic [18:0]           srch_vppn;
    logic [9:0]            srch_asid;
    logic [TLBNUMSIZE-1:0] srch_index;
    logic                  srch_ne;

    // TLB read port
    logic [TLBNUMSIZE-1:0] r_index;
    logic [5:0]            r_ps;
    logic [9:0]            r_asid;
    logic                  r_ne;
    logic                  r_g;
    logic [18:0]           r_vppn;
    phytran_item_t         r_phytran0;
    phytran_item_t         r_phytran1;

    // TLB write port
    logic                  we;
    logic [TLBNUMSIZE-1:0] w_index;
    logic [5:0]            w_ps;
    logic                  w_ne;
    logic [9:0]            w_asid;
    logic [18:0]           w_vppn;
    logic                  w_g;
    phytran_item_t         w_phytran0;
    phytran_item_t         w_phytran1;

    // TLB flush port
    logic                  fe;
    logic [9:0]            f_asid;
    logic [18:0]           f_va;
    logic [2:0]            f_op;

    // completion and CSR write-back
    logic                  done;
    logic                  op_err;
    logic                  wr_idx_en;
    logic                  wr_ehi_en;
    logic                  wr_elo_en;
    logic                  wr_asid_en;
    logic [TLBNUMSIZE-1:0] o_index;
    logic                  o_ne;
    logic [5:0]            o_ps;
    logic [18:0]           o_vppn;
    logic [9:0]            o_asid;
    phytran_item_t         o_elo0;
    phytran_item_t         o_elo1;
    logic                  o_g;

    modport slave (
        input  op_valid, op_code, inv_op, inv_asid, inv_va,
        input  csr_idx_index, csr_idx_ps, csr_idx_ne, csr_ehi_vppn, csr_asid,
        input  csr_elo0, csr_elo1, csr_elo_g, csr_ecode_refill,
        input  srch_index, srch_ne,
        input  r_ps, r_asid, r_ne, r_g, r_vppn, r_phytran0, r_phytran1,
        output op_ready, srch_vppn, srch_asid, r_index,
        output we, w_index, w_ps, w_ne, w_asid, w_vppn, w_g, w_phytran0, w_phytran1,
        output fe, f_asid, f_va, f_op,
        output done, op_err, wr_idx_en, wr_ehi_en, wr_elo_en, wr_asid_en,
        output o_index, o_ne, o_ps, o_vppn, o_asid, o_elo0, o_elo1, o_g
    );

    modport master (
        output op_valid, op_code, inv_op, inv_asid, inv_va,
        output csr_idx_index, csr_idx_ps, csr_idx_ne, csr_ehi_vppn, csr_asid,
        output csr_elo0, csr_elo1, csr_elo_g, csr_ecode_refill,
        output srch_index, srch_ne,
        output r_ps, r_asid, r_ne, r_g, r_vppn, r_phytran0, r_phytran1,
        input  op_ready, srch_vppn, srch_asid, r_index,
        input  we, w_index, w_ps, w_ne, w_asid, w_vppn, w_g, w_phytran0, w_phytran1,
        input  fe, f_asid, f_va, f_op,
        input  done, op_err, wr_idx_en, wr_ehi_en, wr_elo_en, wr_asid_en,
        input  o_index, o_ne, o_ps, o_vppn, o_asid, o_elo0, o_elo1, o_g
    );
endinterface

// File: rtl/tlb_op_ctrl.sv
// TLB maintenance sequencer (TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB): IDLE -> EXEC -> RESP,
// driving the TLB ports during EXEC and pulsing CSR write-back enables in RESP.
`timescale 1ns/1ps

module tlb_op_ctrl
    import tlb_op_pkg::*;
#(
    parameter int TLBNUM     = 16,
    parameter int TLBNUMSIZE = 4
) (
    input  logic         clk,
    input  logic         reset,
    tlb_op_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam logic [2:0] OP_SRCH    = 3'd0;
    localparam logic [2:0] OP_RD      = 3'd1;
    localparam logic [2:0] OP_WR      = 3'd2;
    localparam logic [2:0] OP_FILL    = 3'd3;
    localparam logic [2:0] OP_INV     = 3'd4;
    localparam logic [2:0] INV_OP_MAX = 3'd6;
    localparam logic [TLBNUMSIZE-1:0] FILL_LAST = TLBNUMSIZE'(TLBNUM - 1);

    state_e                state_q;
    logic [TLBNUMSIZE-1:0] fill_ctr_q;
    logic [TLBNUMSIZE-1:0] fill_ctr_d;

    logic [2:0]            op_q;
    logic                  err_q;
    logic [TLBNUMSIZE-1:0] idx_q;
    logic                  op_ready_q;
    logic                  done_q;
    logic                  op_err_q;

    logic                  we_q;
    logic [TLBNUMSIZE-1:0] w_index_q;
    logic [5:0]            w_ps_q;
    logic                  w_ne_q;
    logic [9:0]            w_asid_q;
    logic [18:0]           w_vppn_q;
    logic                  w_g_q;
    phytran_item_t         w_p0_q;
    phytran_item_t         w_p1_q;

    logic [18:0]           srch_vppn_q;
    logic [9:0]            srch_asid_q;
    logic [TLBNUMSIZE-1:0] r_index_q;

    logic                  fe_q;
    logic [2:0]            f_op_q;
    logic [9:0]            f_asid_q;
    logic [18:0]           f_va_q;

    logic                  wr_idx_en_q;
    logic                  wr_ehi_en_q;
    logic                  wr_elo_en_q;
    logic                  wr_asid_en_q;
    logic [TLBNUMSIZE-1:0] o_index_q;
    logic                  o_ne_q;
    logic [5:0]            o_ps_q;
    logic [18:0]           o_vppn_q;
    logic [9:0]            o_asid_q;
    phytran_item_t         o_elo0_q;
    phytran_item_t         o_elo1_q;
    logic                  o_g_q;

    // Next value of the free-running FILL victim counter.
    always_comb begin
        fill_ctr_d = fill_ctr_q;
        if (fill_ctr_q == FILL_LAST) begin
            fill_ctr_d = '0;
        end else begin
            fill_ctr_d = fill_ctr_q + {{(TLBNUMSIZE-1){1'b0}}, 1'b1};
        end
    end

    // FILL victim counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_ctr_q <= '0;
        end else begin
            fill_ctr_q <= fill_ctr_d;
        end
    end

    // Sequencer FSM; every output, including the TLB port data, is a register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            op_q         <= 3'd0;
            err_q        <= 1'b0;
            idx_q        <= '0;
            op_ready_q   <= 1'b1;
            done_q       <= 1'b0;
            op_err_q     <= 1'b0;
            we_q         <= 1'b0;
            w_index_q    <= '0;
            w_ps_q       <= 6'd0;
            w_ne_q       <= 1'b0;
            w_asid_q     <= 10'd0;
            w_vppn_q     <= 19'd0;
            w_g_q        <= 1'b0;
            w_p0_q       <= '0;
            w_p1_q       <= '0;
            srch_vppn_q  <= 19'd0;
            srch_asid_q  <= 10'd0;
            r_index_q    <= '0;
            fe_q         <= 1'b0;
            f_op_q       <= 3'd0;
            f_asid_q     <= 10'd0;
            f_va_q       <= 19'd0;
            wr_idx_en_q  <= 1'b0;
            wr_ehi_en_q  <= 1'b0;
            wr_elo_en_q  <= 1'b0;
            wr_asid_en_q <= 1'b0;
            o_index_q    <= '0;
            o_ne_q       <= 1'b0;
            o_ps_q       <= 6'd0;
            o_vppn_q     <= 19'd0;
            o_asid_q     <= 10'd0;
            o_elo0_q     <= '0;
            o_elo1_q     <= '0;
            o_g_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q       <= 1'b0;
                    op_err_q     <= 1'b0;
                    wr_idx_en_q  <= 1'b0;
                    wr_ehi_en_q  <= 1'b0;
                    wr_elo_en_q  <= 1'b0;
                    wr_asid_en_q <= 1'b0;
                    if (bus.op_valid) begin
                        state_q     <= S_EXEC;
                        op_ready_q  <= 1'b0;
                        op_q        <= bus.op_code;
                        idx_q       <= bus.csr_idx_index;
                        err_q       <= (bus.op_code > OP_INV) ||
                                       ((bus.op_code == OP_INV) && (bus.inv_op > INV_OP_MAX));
                        // The snapshot goes straight into the port registers so that
                        // later CSR changes cannot leak into the op in flight.
                        we_q        <= (bus.op_code == OP_WR) || (bus.op_code == OP_FILL);
                        w_index_q   <= (bus.op_code == OP_FILL) ? fill_ctr_q : bus.csr_idx_index;
                        w_ne_q      <= bus.csr_ecode_refill ? 1'b0 : bus.csr_idx_ne;
                        w_ps_q      <= bus.csr_idx_ps;
                        w_asid_q    <= bus.csr_asid;
                        w_vppn_q    <= bus.csr_ehi_vppn;
                        w_g_q       <= bus.csr_elo_g;
                        w_p0_q      <= bus.csr_elo0;
                        w_p1_q      <= bus.csr_elo1;
                        srch_vppn_q <= bus.csr_ehi_vppn;
                        srch_asid_q <= bus.csr_asid;
                        r_index_q   <= bus.csr_idx_index;
                        fe_q        <= (bus.op_code == OP_INV) && (bus.inv_op <= INV_OP_MAX);
                        f_op_q      <= bus.inv_op;
                        f_asid_q    <= bus.inv_asid;
                        f_va_q      <= bus.inv_va;
                    end else begin
                        state_q    <= S_IDLE;
                        op_ready_q <= 1'b1;
                        we_q       <= 1'b0;
                        fe_q       <= 1'b0;
                    end
                end
                S_EXEC: begin
                    state_q  <= S_RESP;
                    we_q     <= 1'b0;
                    fe_q     <= 1'b0;
                    done_q   <= 1'b1;
                    op_err_q <= err_q;
                    case (op_q)
                        OP_SRCH: begin
                            wr_idx_en_q <= 1'b1;
                            if (!bus.srch_ne) begin
                                o_ne_q    <= 1'b0;
                                o_index_q <= bus.srch_index;
                            end else begin
                                o_ne_q    <= 1'b1;
                                o_index_q <= idx_q;
                            end
                        end
                        OP_RD: begin
                            wr_idx_en_q  <= 1'b1;
                            wr_ehi_en_q  <= 1'b1;
                            wr_elo_en_q  <= 1'b1;
                            wr_asid_en_q <= 1'b1;
                            o_index_q    <= idx_q;
                            if (!bus.r_ne) begin
                                o_ne_q   <= 1'b0;
                                o_ps_q   <= bus.r_ps;
                                o_vppn_q <= bus.r_vppn;
                                o_asid_q <= bus.r_asid;
                                o_elo0_q <= bus.r_phytran0;
                                o_elo1_q <= bus.r_phytran1;
                                o_g_q    <= bus.r_g;
                            end else begin
                                // An invalid entry reads back as all-zero CSR content.
                                o_ne_q   <= 1'b1;
                                o_ps_q   <= 6'd0;
                                o_vppn_q <= 19'd0;
                                o_asid_q <= 10'd0;
                                o_elo0_q <= '0;
                                o_elo1_q <= '0;
                                o_g_q    <= 1'b0;
                            end
                        end
                        default: begin
                            wr_idx_en_q <= 1'b0;
                        end
                    endcase
                end
                S_RESP: begin
                    state_q      <= S_IDLE;
                    op_ready_q   <= 1'b1;
                    done_q       <= 1'b0;
                    op_err_q     <= 1'b0;
                    wr_idx_en_q  <= 1'b0;
                    wr_ehi_en_q  <= 1'b0;
                    wr_elo_en_q  <= 1'b0;
                    wr_asid_en_q <= 1'b0;
                end
                default: begin
                    state_q    <= S_IDLE;
                    op_ready_q <= 1'b1;
                    done_q     <= 1'b0;
                    op_err_q   <= 1'b0;
                    we_q       <= 1'b0;
                    fe_q       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.op_ready   = op_ready_q;
    assign bus.done       = done_q;
    assign bus.op_err     = op_err_q;

    assign bus.srch_vppn  = srch_vppn_q;
    assign bus.srch_asid  = srch_asid_q;
    assign bus.r_index    = r_index_q;

    assign bus.we         = we_q;
    assign bus.w_index    = w_index_q;
    assign bus.w_ps       = w_ps_q;
    assign bus.w_ne       = w_ne_q;
    assign bus.w_asid     = w_asid_q;
    assign bus.w_vppn     = w_vppn_q;
    assign bus.w_g        = w_g_q;
    assign bus.w_phytran0 = w_p0_q;
    assign bus.w_phytran1 = w_p1_q;

    assign bus.fe         = fe_q;
    assign bus.f_op       = f_op_q;
    assign bus.f_asid     = f_asid_q;
    assign bus.f_va       = f_va_q;

    assign bus.wr_idx_en  = wr_idx_en_q;
    assign bus.wr_ehi_en  = wr_ehi_en_q;
    assign bus.wr_elo_en  = wr_elo_en_q;
    assign bus.wr_asid_en = wr_asid_en_q;
    assign bus.o_index    = o_index_q;
    assign bus.o_ne       = o_ne_q;
    assign bus.o_ps       = o_ps_q;
    assign bus.o_vppn     = o_vppn_q;
    assign bus.o_asid     = o_asid_q;
    assign bus.o_elo0     = o_elo0_q;
    assign bus.o_elo1     = o_elo1_q;
    assign bus.o_g        = o_g_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl with a behavioural 16-entry TLB and an expected-result queue.
`timescale 1ns/1ps

module tb_tlb_op_ctrl;
    import tlb_op_pkg::*;

    typedef struct {
        logic [3:0]    en;
        logic          err;
        logic [3:0]    idx;
        logic          ne;
        logic [5:0]    ps;
        logic [18:0]   vppn;
        logic [9:0]    asid;
        phytran_item_t e0;
        phytran_item_t e1;
        logic          g;
        int            we_n;
        int            fe_n;
        logic [3:0]    w_idx;
        logic          w_ne;
        logic [5:0]    w_ps;
        logic [2:0]    f_op;
        logic [9:0]    f_asid;
        logic [18:0]   f_va;
    } exp_t;

    typedef struct {
        logic [18:0]   vppn;
        logic [9:0]    asid;
        logic [5:0]    ps;
        logic          ne;
        logic          g;
        phytran_item_t p0;
        phytran_item_t p1;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   edges = 0;
    exp_t exp_q[$];
    ent_t tlb [16];

    tlb_op_ctrl_if #(.TLBNUMSIZE(4)) bus ();

    tlb_op_ctrl #(.TLBNUM(16), .TLBNUMSIZE(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Posedges seen since reset release; equals the DUT fill counter value.
    always @(posedge clk or negedge reset) begin
        if (!reset) edges <= 0;
        else        edges <= edges + 1;
    end

    // TLB storage: known contents on reset, commit on we.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                tlb[i].vppn <= 19'(i * 1234 + 77);
                tlb[i].asid <= 10'(i + 100);
                tlb[i].ps   <= 6'd21;
                tlb[i].ne   <= 1'b1;
                tlb[i].g    <= 1'b1;
                tlb[i].p0   <= phytran_item_t'(26'h2AAAAAA);
                tlb[i].p1   <= phytran_item_t'(26'h1555555);
            end
            tlb[5].vppn <= 19'h12345;
            tlb[5].asid <= 10'h007;
            tlb[5].ne   <= 1'b0;
            tlb[5].g    <= 1'b0;
        end else if (bus.we) begin
            tlb[bus.w_index].vppn <= bus.w_vppn;
            tlb[bus.w_index].asid <= bus.w_asid;
            tlb[bus.w_index].ps   <= bus.w_ps;
            tlb[bus.w_index].ne   <= bus.w_ne;
            tlb[bus.w_index].g    <= bus.w_g;
            tlb[bus.w_index].p0   <= bus.w_phytran0;
            tlb[bus.w_index].p1   <= bus.w_phytran1;
        end
    end

    // Search and read ports of the TLB.
    always_comb begin
        logic       hit;
        logic [3:0] hidx;
        hit  = 1'b0;
        hidx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (!hit && !tlb[i].ne && (tlb[i].vppn == bus.srch_vppn) &&
                (tlb[i].g || (tlb[i].asid == bus.srch_asid))) begin
                hit  = 1'b1;
                hidx = 4'(i);
            end
        end
        bus.srch_ne    = ~hit;
        bus.srch_index = hidx;
        bus.r_ps       = tlb[bus.r_index].ps;
        bus.r_asid     = tlb[bus.r_index].asid;
        bus.r_ne       = tlb[bus.r_index].ne;
        bus.r_g        = tlb[bus.r_index].g;
        bus.r_vppn     = tlb[bus.r_index].vppn;
        bus.r_phytran0 = tlb[bus.r_index].p0;
        bus.r_phytran1 = tlb[bus.r_index].p1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t blank();
        exp_t e;
        e.en = 4'd0; e.err = 1'b0; e.idx = 4'd0; e.ne = 1'b0; e.ps = 6'd0;
        e.vppn = 19'd0; e.asid = 10'd0; e.e0 = '0; e.e1 = '0; e.g = 1'b0;
        e.we_n = 0; e.fe_n = 0; e.w_idx = 4'd0; e.w_ne = 1'b0; e.w_ps = 6'd0;
        e.f_op = 3'd0; e.f_asid = 10'd0; e.f_va = 19'd0;
        return e;
    endfunction

    task automatic set_csr(input logic [3:0] idx, input logic [5:0] ps, input logic ne,
                           input logic [18:0] vppn, input logic [9:0] asid,
                           input phytran_item_t e0, input phytran_item_t e1,
                           input logic g, input logic refill);
        bus.csr_idx_index = idx;  bus.csr_idx_ps = ps;   bus.csr_idx_ne = ne;
        bus.csr_ehi_vppn  = vppn; bus.csr_asid   = asid;
        bus.csr_elo0 = e0; bus.csr_elo1 = e1; bus.csr_elo_g = g;
        bus.csr_ecode_refill = refill;
    endtask

    task automatic set_inv(input logic [2:0] op, input logic [9:0] asid, input logic [18:0] va);
        bus.inv_op = op; bus.inv_asid = asid; bus.inv_va = va;
    endtask

    task automatic scramble();
        bus.csr_idx_index = 4'($urandom); bus.csr_idx_ps = 6'($urandom);
        bus.csr_idx_ne = 1'($urandom);    bus.csr_ehi_vppn = 19'($urandom);
        bus.csr_asid = 10'($urandom);     bus.csr_elo0 = phytran_item_t'(26'($urandom));
        bus.csr_elo1 = phytran_item_t'(26'($urandom));
        bus.csr_elo_g = 1'($urandom);     bus.csr_ecode_refill = 1'($urandom);
        bus.inv_op = 3'($urandom); bus.inv_asid = 10'($urandom); bus.inv_va = 19'($urandom);
    endtask

    // Issue one op, observe EXEC/RESP, then compare against the queued expectation.
    task automatic run_op(input logic [2:0] code, input exp_t e);
        exp_t        x;
        int          lat, we_n, fe_n;
        logic [3:0]  c_widx;
        logic        c_wne;
        logic [5:0]  c_wps;
        logic [2:0]  c_fop;
        logic [9:0]  c_fasid;
        logic [18:0] c_fva;
        exp_q.push_back(e);
        chk("ready_idle", 64'(bus.op_ready), 64'(1'b1));
        bus.op_code  = code;
        bus.op_valid = 1'b1;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        scramble();
        lat = 0; we_n = 0; fe_n = 0;
        c_widx = 4'd0; c_wne = 1'b0; c_wps = 6'd0; c_fop = 3'd0; c_fasid = 10'd0; c_fva = 19'd0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) chk("busy_exec", 64'(bus.op_ready), 64'(1'b0));
            if (bus.we === 1'b1) begin
                we_n++; c_widx = bus.w_index; c_wne = bus.w_ne; c_wps = bus.w_ps;
            end
            if (bus.fe === 1'b1) begin
                fe_n++; c_fop = bus.f_op; c_fasid = bus.f_asid; c_fva = bus.f_va;
            end
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
        x = exp_q.pop_front();
        chk("done_latency", 64'(lat), 64'(2));
        chk("op_err", 64'(bus.op_err), 64'(x.err));
        chk("csr_enables", 64'({bus.wr_asid_en, bus.wr_elo_en, bus.wr_ehi_en, bus.wr_idx_en}), 64'(x.en));
        chk("we_pulses", 64'(we_n), 64'(x.we_n));
        chk("fe_pulses", 64'(fe_n), 64'(x.fe_n));
        if (x.en[0]) begin
            chk("o_index", 64'(bus.o_index), 64'(x.idx));
            chk("o_ne", 64'(bus.o_ne), 64'(x.ne));
        end
        if (x.en[3]) begin
            chk("o_ps", 64'(bus.o_ps), 64'(x.ps));
            chk("o_vppn", 64'(bus.o_vppn), 64'(x.vppn));
            chk("o_asid", 64'(bus.o_asid), 64'(x.asid));
            chk("o_elo0", 64'(bus.o_elo0), 64'(x.e0));
            chk("o_elo1", 64'(bus.o_elo1), 64'(x.e1));
            chk("o_g", 64'(bus.o_g), 64'(x.g));
        end
        if (x.we_n > 0) begin
            chk("w_index", 64'(c_widx), 64'(x.w_idx));
            chk("w_ne", 64'(c_wne), 64'(x.w_ne));
            chk("w_ps", 64'(c_wps), 64'(x.w_ps));
        end
        if (x.fe_n > 0) begin
            chk("f_op", 64'(c_fop), 64'(x.f_op));
            chk("f_asid", 64'(c_fasid), 64'(x.f_asid));
            chk("f_va", 64'(c_fva), 64'(x.f_va));
        end
        @(negedge clk);
        chk("ready_after", 64'(bus.op_ready), 64'(1'b1));
        chk("done_single", 64'(bus.done), 64'(1'b0));
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t          e;
        phytran_item_t pa, pb, pz;
        pa = phytran_item_t'(26'h1234567);
        pb = phytran_item_t'(26'h0FEDCBA);
        pz = '0;
        bus.op_valid = 1'b0;
        bus.op_code  = 3'd0;
        set_inv(3'd0, 10'd0, 19'd0);
        set_csr(4'd0, 6'd0, 1'b0, 19'd0, 10'd0, pz, pz, 1'b0, 1'b0);

        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(bus.op_ready), 64'(1'b1));
        chk("rst_done", 64'(bus.done), 64'(1'b0));
        chk("rst_we", 64'(bus.we), 64'(1'b0));
        chk("rst_fe", 64'(bus.fe), 64'(1'b0));
        chk("rst_err", 64'(bus.op_err), 64'(1'b0));
        chk("rst_en", 64'({bus.wr_asid_en, bus.wr_elo_en, bus.wr_ehi_en, bus.wr_idx_en}), 64'(4'd0));
        chk("rst_o_index", 64'(bus.o_index), 64'(4'd0));
        reset = 1'b1;
        @(posedge clk); #1;

        // SRCH hit on entry 5
        set_csr(4'd2, 6'd0, 1'b0, 19'h12345, 10'h007, pz, pz, 1'b0, 1'b0);
        e = blank(); e.en = 4'b0001; e.idx = 4'd5; e.ne = 1'b0;
        run_op(3'd0, e);

        // SRCH miss keeps the CSR index
        set_csr(4'd9, 6'd0, 1'b0, 19'h54321, 10'h007, pz, pz, 1'b0, 1'b0);
        e = blank(); e.en = 4'b0001; e.idx = 4'd9; e.ne = 1'b1;
        run_op(3'd0, e);

        // WR index 3 during refill: NE forced to 0
        set_csr(4'd3, 6'd12, 1'b1, 19'h0ABCD, 10'h055, pa, pb, 1'b1, 1'b1);
        e = blank(); e.we_n = 1; e.w_idx = 4'd3; e.w_ne = 1'b0; e.w_ps = 6'd12;
        run_op(3'd2, e);

        // RD index 3 returns the written entry
        set_csr(4'd3, 6'd0, 1'b0, 19'd0, 10'd0, pz, pz, 1'b0, 1'b0);
        e = blank(); e.en = 4'b1111; e.idx = 4'd3; e.ne = 1'b0; e.ps = 6'd12;
        e.vppn = 19'h0ABCD; e.asid = 10'h055; e.e0 = pa; e.e1 = pb; e.g = 1'b1;
        run_op(3'd1, e);

        // RD of an invalid entry zeroes everything
        set_csr(4'd10, 6'd0, 1'b0, 19'd0, 10'd0, pz, pz, 1'b0, 1'b0);
        e = blank(); e.en = 4'b1111; e.idx = 4'd10; e.ne = 1'b1;
        run_op(3'd1, e);

        // INVTLB op 5
        set_inv(3'd5, 10'd3, 19'h00100);
        e = blank(); e.fe_n = 1; e.f_op = 3'd5; e.f_asid = 10'd3; e.f_va = 19'h00100;
        run_op(3'd4, e);

        // INVTLB op 7 is illegal
        set_inv(3'd7, 10'd3, 19'h00100);
        e = blank(); e.err = 1'b1;
        run_op(3'd4, e);

        // illegal op_code
        set_inv(3'd1, 10'd0, 19'd0);
        e = blank(); e.err = 1'b1;
        run_op(3'd6, e);

        // FILL at counter 15, then again 16 cycles later
        for (int k = 0; k < 40 && (edges % 16) != 15; k++) begin
            @(posedge clk); #1;
        end
        set_csr(4'd1, 6'd13, 1'b0, 19'h11111, 10'h001, pa, pb, 1'b0, 1'b0);
        e = blank(); e.we_n = 1; e.w_idx = 4'(edges % 16); e.w_ne = 1'b0; e.w_ps = 6'd13;
        chk("fill_slot_a", 64'(e.w_idx), 64'(4'd15));
        run_op(3'd3, e);
        for (int k = 0; k < 40 && (edges % 16) != 15; k++) begin
            @(posedge clk); #1;
        end
        set_csr(4'd1, 6'd14, 1'b1, 19'h22222, 10'h002, pb, pa, 1'b1, 1'b0);
        e = blank(); e.we_n = 1; e.w_idx = 4'(edges % 16); e.w_ne = 1'b1; e.w_ps = 6'd14;
        run_op(3'd3, e);

        // reset during EXEC of a WR drops it
        set_csr(4'd7, 6'd12, 1'b0, 19'h33333, 10'h003, pa, pb, 1'b0, 1'b0);
        bus.op_code  = 3'd2;
        bus.op_valid = 1'b1;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        #1;
        chk("exec_we", 64'(bus.we), 64'(1'b1));
        reset = 1'b0;
        #1;
        chk("midrst_we", 64'(bus.we), 64'(1'b0));
        chk("midrst_ready", 64'(bus.op_ready), 64'(1'b1));
        chk("midrst_o_index", 64'(bus.o_index), 64'(4'd0));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        set_csr(4'd7, 6'd0, 1'b0, 19'd0, 10'd0, pz, pz, 1'b0, 1'b0);
        e = blank(); e.en = 4'b1111; e.idx = 4'd7; e.ne = 1'b1;
        run_op(3'd1, e);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlb_op_ctrl.md
# tlb_op_ctrl

Sequencer for the TLB-maintenance instructions: TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB. It sits between the EX stage / CSR file and the TLB array. It drives the TLB's read, write and flush ports and one dedicated search port. It returns results to the CSR file as single-cycle write-enable pulses. It is a multi-cycle unit with a valid/ready handshake, so the pipeline stalls while it is busy.

## Interface
Parameters:
- TLBNUM, 16, number of TLB entries.
- TLBNUMSIZE, 4, index width; equals log2(TLBNUM).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- op_valid  in  1  instruction request.
- op_ready  out  1  high only in IDLE.
- op_code  in  3  0=SRCH, 1=RD, 2=WR, 3=FILL, 4=INV; 5–7 are illegal.
- inv_op  in  3  INVTLB op field.
- inv_asid  in  10  rj[9:0].
- inv_va  in  19  rk[31:13].
- csr_idx_index  in  TLBNUMSIZE  TLBIDX.INDEX.
- csr_idx_ps  in  6  TLBIDX.PS.
- csr_idx_ne  in  1  TLBIDX.NE.
- csr_ehi_vppn  in  19  TLBEHI.VPPN.
- csr_asid  in  10  ASID.ASID.
- csr_elo0  in  PhytranItem  TLBELO0 fields.
- csr_elo1  in  PhytranItem  TLBELO1 fields.
- csr_elo_g  in  1  TLBELO0.G & TLBELO1.G.
- csr_ecode_refill  in  1  ESTAT.Ecode==0x3F.
- srch_vppn  out  19  to TLB search port.
- srch_asid  out  10  to TLB search port.
- srch_index  in  TLBNUMSIZE  search result index.
- srch_ne  in  1  search result: 1 = miss.
- r_index  out  TLBNUMSIZE  to TLB.
- r_ps, r_asid, r_ne, r_g, r_vppn, r_phytran0, r_phytran1  in  read data from TLB.
- we, w_index, w_ps, w_ne, w_asid, w_vppn, w_g, w_phytran0, w_phytran1  out  TLB write port.
- fe, f_asid, f_va, f_op  out  TLB flush port.
- done  out  1  one-cycle completion pulse.
- op_err  out  1  illegal op_code, or inv_op>6; pulses with done.
- wr_idx_en, wr_ehi_en, wr_elo_en, wr_asid_en  out  1  CSR write enables.
- o_index  out  TLBNUMSIZE  result for TLBIDX.INDEX.
- o_ne  out  1  result for TLBIDX.NE.
- o_ps  out  6  result for TLBIDX.PS.
- o_vppn  out  19  result for TLBEHI.VPPN.
- o_asid  out  10  result for ASID.ASID.
- o_elo0, o_elo1  out  PhytranItem  TLBELO data.
- o_g  out  1  G bit for TLBELO.

## Operation
- States: IDLE → EXEC → RESP → IDLE.
- Accept: op_valid && op_ready in IDLE. At accept, latch op_code, inv_*, all csr_* inputs and fill_ctr; go to EXEC.
- fill_ctr: TLBNUMSIZE-bit free-running counter. Increments every cycle, wraps TLBNUM-1→0, reset 0.
- EXEC, by op:
  - SRCH: srch_vppn/srch_asid = latched ehi_vppn/asid. Register srch_ne and srch_index.
  - RD: r_index = latched index. Register all r_* data.
  - WR/FILL: we=1 for this cycle. w_index = latched index (WR) or latched fill_ctr (FILL). w_ne = refill ? 0 : idx_ne. Remaining w_* come from the latched CSR values; w_g = elo_g.
  - INV: if inv_op≤6, fe=1 with f_op/f_asid/f_va from the latched values. Otherwise no fe; set the err flag.
  - Illegal op_code: no TLB activity; set the err flag.
- RESP: done=1, op_err=err flag. CSR enables by op:
  - SRCH: wr_idx_en=1. Hit: o_ne=0, o_index=srch_index. Miss: o_ne=1, o_index=latched index (unchanged).
  - RD, r_ne=0: all four enables set. o_* = read data, o_ne=0.
  - RD, r_ne=1: all four enables set. o_ne=1, o_index = latched index. o_ps, o_vppn, o_asid, o_elo*, o_g all 0.
  - WR/FILL/INV: no CSR enables.
- o_* outputs hold their values outside RESP. Consumers must qualify them with the enables.
- When idle, srch_*, r_index and w_*/f_* data are don't-care; we and fe are 0.

## Timing
- Every op completes on a fixed schedule: accept edge → EXEC (1 cycle) → RESP (1 cycle, done). op_ready returns in the cycle after RESP.
- Back-to-back ops: next accept no earlier than 3 cycles after the previous accept.
- we and fe are high for exactly one cycle, during EXEC. The TLB commits on the EXEC→RESP edge, so a following SRCH/RD sees the new contents.
- CSR inputs are sampled only at accept. Changes after accept do not affect the op in flight.
- Reset (async, any state):
  - state=IDLE, op_ready=1.
  - done, op_err, we, fe and all CSR enables = 0.
  - All o_* = 0; fill_ctr=0.
  - An op in flight is dropped with no partial write.
- FILL index: value of fill_ctr at the accept edge. Wraps 15→0 for TLBNUM=16.

## Test plan
- SRCH hit: entry 5 holds vppn 0x12345, asid 0x7 → done 2 cycles after accept; wr_idx_en=1, o_ne=0, o_index=5.
- SRCH miss with csr_idx_index=9 → o_ne=1, o_index=9, wr_ehi_en=0.
- WR then RD index 3, ps=12, refill=1 with idx_ne=1: we pulses once with w_ne=0. The subsequent RD returns o_ps=12, o_ne=0 and the written vppn/elo values.
- RD of an invalid entry → o_ne=1, o_ps=0, o_asid=0, o_vppn=0, o_elo0=0, o_elo1=0, o_g=0, all enables 1.
- INV inv_op=5, asid=3, va=0x100 → fe one cycle with f_op=5, f_asid=3, f_va=0x100. INV inv_op=7 → no fe, op_err=1 together with done.
- FILL issued when fill_ctr=15 → w_index=15; a FILL issued 16 cycles later → w_index=15 again. Assert reset mid-EXEC → we drops immediately, op_ready=1.
